shift_unit: RTL and testbench
=============================

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (≥2).
REQ-002 Parameter AMT_W, default 4, width of shift-amount input.
REQ-003 alu_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 alu_rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE or DONE.
REQ-006 operation  input  3  000 pass, 001 SHL, 010 SHR, 011 SAR, 100 ROL, 101 ROR, 110 RCL, 111 RCR.
REQ-007 amount  input  AMT_W  number of single-bit steps, 0..2^AMT_W-1.
REQ-008 in  input  WIDTH  operand; sampled with start.
REQ-009 clear  input  1  synchronous zero of result and carry.
REQ-010 out  output  WIDTH  registered result.
REQ-011 carry_out  output  1  registered carry flag.
REQ-012 busy  output  1  high in SHIFT state.
REQ-013 done  output  1  one-cycle pulse, result valid.

Function
REQ-014 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-015 IDLE/DONE with start=1: capture in, operation and amount; load work=in, wcarry=carry_out, count=amount; go to SHIFT.
REQ-016 SHIFT, count≠0: one step per edge on work/wcarry; count decrements.
REQ-017 SHIFT, count=0: out<=work, carry_out<=wcarry, go to DONE; done=1 for exactly that following cycle.
REQ-018 Latency: done high in the cycle after edge E0+amount+1, where E0 is the start-sampling edge.
REQ-019 DONE without start: next edge goes to IDLE; DONE with start: back-to-back op, no idle cycle.
REQ-020 SHL: work={work[W-2:0],0}, wcarry=work[W-1].
REQ-021 SHR: work={0,work[W-1:1]}, wcarry=work[0].
REQ-022 SAR: work={work[W-1],work[W-1:1]}, wcarry=work[0].
REQ-023 ROL/ROR: WIDTH-bit rotate; wcarry = bit rotated across the boundary.
REQ-024 RCL: work={work[W-2:0],wcarry}, wcarry=work[W-1]; RCR mirror (WIDTH+1-bit rotate).
REQ-025 Pass (000): work and wcarry unchanged every step; output = in, carry unchanged.
REQ-026 amount=0: any operation returns in unchanged, carry_out unchanged.
REQ-027 amount ≥ WIDTH: all steps executed literally (SHL/SHR → 0, SAR → sign fill, rotates wrap modulo).
REQ-028 start in SHIFT ignored; inputs need not be held after E0.
REQ-029 out and carry_out change only on SHIFT→DONE transition or clear; hold otherwise.
REQ-030 clear=1 has priority over everything: out=0, carry_out=0, count=0, state IDLE, done=0; aborts an op in flight, no done pulse.

Reset
REQ-031 alu_rst=1 immediately forces IDLE, out=0, carry_out=0, busy=0, done=0, internal work/count/wcarry=0, independent of alu_clk.
REQ-032 Reset mid-operation discards the op; no done pulse follows reset release.

Configuration
REQ-033 Macro SHIFT_UNIT_FLAGS_EN defined: extra outputs zero_out (1, out==0) and neg_out (1, out[WIDTH-1]), registered with out, reset and cleared to zero_out=1, neg_out=0.
REQ-034 Macro undefined: ports zero_out/neg_out absent; all other behaviour identical.

Verification (WIDTH=8, AMT_W=4)
REQ-035 SHL in=0x81, amount=1, carry 0 -> done after E0+2, out=0x02, carry_out=1.
REQ-036 SAR in=0x80, amount=3 -> out=0xF0, carry_out=0; SHR same -> out=0x10, carry_out=0.
REQ-037 carry_out=1, RCL in=0x80, amount=1 -> out=0x01, carry_out=1; ROR in=0x01, amount=9 -> out=0x80, carry_out=1.
REQ-038 start re-pulsed while busy during SHL amount=5 -> ignored, single done after E0+6; start held in DONE -> next op begins with no IDLE cycle.
REQ-039 clear asserted 2 cycles into SHR amount=7 -> out=0x00, carry_out=0, no done, busy=0 next cycle; with SHIFT_UNIT_FLAGS_EN zero_out=1.
REQ-040 alu_rst asserted between clock edges mid-op -> outputs zero without a clock edge; no done after release.

Source files
------------

// File: rtl/shift_unit.sv
// Multi-cycle shifter/rotator with one single-bit step per clock and an IDLE/SHIFT/DONE handshake.
// Optional zero/negative result flags are enabled by defining SHIFT_UNIT_FLAGS_EN.
module shift_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             alu_clk,
  input  logic             alu_rst,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] in,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             busy,
  output logic             done
`ifdef SHIFT_UNIT_FLAGS_EN
  ,
  output logic             zero_out,
  output logic             neg_out
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_PASS = 3'b000, OP_SHL = 3'b001, OP_SHR = 3'b010, OP_SAR = 3'b011,
    OP_ROL  = 3'b100, OP_ROR = 3'b101, OP_RCL = 3'b110, OP_RCR = 3'b111
  } op_t;

  state_t           r_state, w_next_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_work, w_step_work;
  logic             r_wcarry, w_step_carry;
  logic [AMT_W-1:0] r_count;
  logic             w_accept;
  logic             w_finish;

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_finish = (r_state == S_SHIFT) && (r_count == '0);
  assign busy     = (r_state == S_SHIFT);
  assign done     = (r_state == S_DONE);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge alu_clk or posedge alu_rst) begin
    if (alu_rst) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: defaults first so no path through this block infers a latch.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next_state = S_SHIFT;
        S_SHIFT: if (r_count == '0) w_next_state = S_DONE;
        S_DONE:  w_next_state = start ? S_SHIFT : S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // One single-bit step of the captured operation; RCL/RCR rotate through the carry.
  always_comb begin
    w_step_work  = r_work;
    w_step_carry = r_wcarry;
    case (r_op)
      OP_PASS: ;
      OP_SHL: begin w_step_work = {r_work[WIDTH-2:0], 1'b0};        w_step_carry = r_work[WIDTH-1]; end
      OP_SHR: begin w_step_work = {1'b0, r_work[WIDTH-1:1]};        w_step_carry = r_work[0];       end
      OP_SAR: begin w_step_work = {r_work[WIDTH-1], r_work[WIDTH-1:1]}; w_step_carry = r_work[0];   end
      OP_ROL: begin w_step_work = {r_work[WIDTH-2:0], r_work[WIDTH-1]}; w_step_carry = r_work[WIDTH-1]; end
      OP_ROR: begin w_step_work = {r_work[0], r_work[WIDTH-1:1]};   w_step_carry = r_work[0];       end
      OP_RCL: begin w_step_work = {r_work[WIDTH-2:0], r_wcarry};    w_step_carry = r_work[WIDTH-1]; end
      OP_RCR: begin w_step_work = {r_wcarry, r_work[WIDTH-1:1]};    w_step_carry = r_work[0];       end
      default: ;
    endcase
  end

  always_ff @(posedge alu_clk or posedge alu_rst) begin
    if (alu_rst) begin
      r_op      <= OP_PASS;
      r_work    <= '0;
      r_wcarry  <= 1'b0;
      r_count   <= '0;
      out       <= '0;
      carry_out <= 1'b0;
    end else if (clear) begin
      r_work    <= '0;
      r_wcarry  <= 1'b0;
      r_count   <= '0;
      out       <= '0;
      carry_out <= 1'b0;
    end else if (w_accept) begin
      r_op     <= op_t'(operation);
      r_work   <= in;
      r_wcarry <= carry_out;
      r_count  <= amount;
    end else if (r_state == S_SHIFT) begin
      if (r_count != '0) begin
        r_work   <= w_step_work;
        r_wcarry <= w_step_carry;
        r_count  <= r_count - AMT_W'(1);
      end else begin
        out       <= r_work;
        carry_out <= r_wcarry;
      end
    end
  end

`ifdef SHIFT_UNIT_FLAGS_EN
  // Flags track the value written to out, so they update on the same edge.
  always_ff @(posedge alu_clk or posedge alu_rst) begin
    if (alu_rst) begin
      zero_out <= 1'b1;
      neg_out  <= 1'b0;
    end else if (clear) begin
      zero_out <= 1'b1;
      neg_out  <= 1'b0;
    end else if (w_finish) begin
      zero_out <= (r_work == '0);
      neg_out  <= r_work[WIDTH-1];
    end
  end
`else
  // Flag outputs are not built in this configuration.
  logic w_unused_finish;
  assign w_unused_finish = w_finish;
`endif

endmodule

// File: tb/tb_shift_unit.sv
// Directed self-checking bench for shift_unit (WIDTH=8, AMT_W=4) with hand-computed results.
// Latency, carry chaining, back-to-back starts, clear and asynchronous reset are exercised.
module tb_shift_unit;

  localparam logic [2:0] OP_PASS = 3'b000, OP_SHL = 3'b001, OP_SHR = 3'b010, OP_SAR = 3'b011,
                         OP_ROL  = 3'b100, OP_ROR = 3'b101, OP_RCL = 3'b110, OP_RCR = 3'b111;

  logic       alu_clk, alu_rst, start, clear;
  logic [2:0] operation;
  logic [3:0] amount;
  logic [7:0] din, dout;
  logic       carry_out, busy, done;
`ifdef SHIFT_UNIT_FLAGS_EN
  logic       zero_out, neg_out;
`endif

  int checks = 0;
  int errors = 0;

  shift_unit #(.WIDTH(8), .AMT_W(4)) dut (
    .alu_clk(alu_clk), .alu_rst(alu_rst), .start(start), .operation(operation),
    .amount(amount), .in(din), .clear(clear), .out(dout), .carry_out(carry_out),
    .busy(busy), .done(done)
`ifdef SHIFT_UNIT_FLAGS_EN
    , .zero_out(zero_out), .neg_out(neg_out)
`endif
  );

  initial begin
    alu_clk = 1'b0;
    forever #5 alu_clk = ~alu_clk;
  end

  // Present a request at the falling edge; it is sampled at the next rising edge (E0).
  // Inputs are scrambled afterwards to show they need not be held.
  task automatic launch(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] d);
    @(negedge alu_clk);
    operation = op; amount = amt; din = d; start = 1'b1;
    @(posedge alu_clk); #1;
    start = 1'b0; operation = ~op; amount = ~amt; din = ~d;
  endtask

  // Count rising edges after E0 until done is seen; -1 if the budget runs out.
  task automatic wait_done(input int budget, output int cycles);
    cycles = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge alu_clk); #1;
      if (done === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    alu_rst = 1'b1; start = 1'b0; clear = 1'b0;
    operation = OP_PASS; amount = 4'd0; din = 8'h00;
    repeat (2) @(posedge alu_clk);
    @(negedge alu_clk); alu_rst = 1'b0;
    @(posedge alu_clk); #1;
    checks++; if (dout !== 8'h00)    begin errors++; $display("FAIL reset_out: got %h expected 00", dout); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry_out); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
`ifdef SHIFT_UNIT_FLAGS_EN
    checks++; if (zero_out !== 1'b1)  begin errors++; $display("FAIL reset_zero: got %b expected 1", zero_out); end
    checks++; if (neg_out !== 1'b0)   begin errors++; $display("FAIL reset_neg: got %b expected 0", neg_out); end
`endif
  endtask

  task automatic test_shl;
    int cyc;
    launch(OP_SHL, 4'd1, 8'h81);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL shl_busy: got %b expected 1", busy); end
    wait_done(40, cyc);
    checks++; if (cyc != 2)            begin errors++; $display("FAIL shl_latency: got %0d expected 2", cyc); end
    checks++; if (dout !== 8'h02)      begin errors++; $display("FAIL shl_out: got %h expected 02", dout); end
    checks++; if (carry_out !== 1'b1)  begin errors++; $display("FAIL shl_carry: got %b expected 1", carry_out); end
  endtask

  task automatic test_sar_shr;
    int cyc;
    launch(OP_SAR, 4'd3, 8'h80);
    wait_done(40, cyc);
    checks++; if (cyc != 4)            begin errors++; $display("FAIL sar_latency: got %0d expected 4", cyc); end
    checks++; if (dout !== 8'hF0)      begin errors++; $display("FAIL sar_out: got %h expected f0", dout); end
    checks++; if (carry_out !== 1'b0)  begin errors++; $display("FAIL sar_carry: got %b expected 0", carry_out); end
`ifdef SHIFT_UNIT_FLAGS_EN
    checks++; if (neg_out !== 1'b1)    begin errors++; $display("FAIL sar_neg: got %b expected 1", neg_out); end
    checks++; if (zero_out !== 1'b0)   begin errors++; $display("FAIL sar_zero: got %b expected 0", zero_out); end
`endif
    launch(OP_SHR, 4'd3, 8'h80);
    wait_done(40, cyc);
    checks++; if (dout !== 8'h10)      begin errors++; $display("FAIL shr_out: got %h expected 10", dout); end
    checks++; if (carry_out !== 1'b0)  begin errors++; $display("FAIL shr_carry: got %b expected 0", carry_out); end
  endtask

  task automatic test_carry_rotates;
    int cyc;
    launch(OP_SHL, 4'd1, 8'h80);
    wait_done(40, cyc);
    checks++; if (carry_out !== 1'b1)  begin errors++; $display("FAIL setc_carry: got %b expected 1", carry_out); end
    launch(OP_RCL, 4'd1, 8'h80);
    wait_done(40, cyc);
    checks++; if (dout !== 8'h01)      begin errors++; $display("FAIL rcl_out: got %h expected 01", dout); end
    checks++; if (carry_out !== 1'b1)  begin errors++; $display("FAIL rcl_carry: got %b expected 1", carry_out); end
    launch(OP_ROR, 4'd9, 8'h01);
    wait_done(40, cyc);
    checks++; if (cyc != 10)           begin errors++; $display("FAIL ror9_latency: got %0d expected 10", cyc); end
    checks++; if (dout !== 8'h80)      begin errors++; $display("FAIL ror9_out: got %h expected 80", dout); end
    checks++; if (carry_out !== 1'b1)  begin errors++; $display("FAIL ror9_carry: got %b expected 1", carry_out); end
  endtask

  task automatic test_pass_amount0;
    int cyc;
    launch(OP_PASS, 4'd3, 8'h5A);
    wait_done(40, cyc);
    checks++; if (cyc != 4)            begin errors++; $display("FAIL pass_latency: got %0d expected 4", cyc); end
    checks++; if (dout !== 8'h5A)      begin errors++; $display("FAIL pass_out: got %h expected 5a", dout); end
    checks++; if (carry_out !== 1'b1)  begin errors++; $display("FAIL pass_carry: got %b expected 1", carry_out); end
    launch(OP_SHL, 4'd0, 8'h3C);
    wait_done(40, cyc);
    checks++; if (cyc != 1)            begin errors++; $display("FAIL amt0_latency: got %0d expected 1", cyc); end
    checks++; if (dout !== 8'h3C)      begin errors++; $display("FAIL amt0_out: got %h expected 3c", dout); end
    checks++; if (carry_out !== 1'b1)  begin errors++; $display("FAIL amt0_carry: got %b expected 1", carry_out); end
  endtask

  task automatic test_large_amount;
    int cyc;
    launch(OP_SHL, 4'd15, 8'hFF);
    wait_done(40, cyc);
    checks++; if (dout !== 8'h00)      begin errors++; $display("FAIL shl15_out: got %h expected 00", dout); end
    checks++; if (carry_out !== 1'b0)  begin errors++; $display("FAIL shl15_carry: got %b expected 0", carry_out); end
    launch(OP_SAR, 4'd15, 8'h80);
    wait_done(40, cyc);
    checks++; if (dout !== 8'hFF)      begin errors++; $display("FAIL sar15_out: got %h expected ff", dout); end
    checks++; if (carry_out !== 1'b1)  begin errors++; $display("FAIL sar15_carry: got %b expected 1", carry_out); end
    launch(OP_ROL, 4'd15, 8'h81);
    wait_done(40, cyc);
    checks++; if (dout !== 8'hC0)      begin errors++; $display("FAIL rol15_out: got %h expected c0", dout); end
    checks++; if (carry_out !== 1'b0)  begin errors++; $display("FAIL rol15_carry: got %b expected 0", carry_out); end
    launch(OP_RCR, 4'd2, 8'h01);
    wait_done(40, cyc);
    checks++; if (dout !== 8'h80)      begin errors++; $display("FAIL rcr_out: got %h expected 80", dout); end
    checks++; if (carry_out !== 1'b0)  begin errors++; $display("FAIL rcr_carry: got %b expected 0", carry_out); end
  endtask

  task automatic test_start_ignored;
    int cyc;
    int pulses;
    launch(OP_SHL, 4'd5, 8'h01);
    @(negedge alu_clk);
    operation = OP_PASS; amount = 4'd0; din = 8'hAA; start = 1'b1;
    @(posedge alu_clk); #1;
    start = 1'b0;
    wait_done(40, cyc);
    if (cyc > 0) cyc = cyc + 1;
    checks++; if (cyc != 6)            begin errors++; $display("FAIL repulse_latency: got %0d expected 6", cyc); end
    checks++; if (dout !== 8'h20)      begin errors++; $display("FAIL repulse_out: got %h expected 20", dout); end
    checks++; if (carry_out !== 1'b0)  begin errors++; $display("FAIL repulse_carry: got %b expected 0", carry_out); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge alu_clk); #1;
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses != 0)         begin errors++; $display("FAIL repulse_extra_done: got %0d expected 0", pulses); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    launch(OP_SHR, 4'd1, 8'h80);
    wait_done(40, cyc);
    checks++; if (dout !== 8'h40)      begin errors++; $display("FAIL b2b_first_out: got %h expected 40", dout); end
    @(negedge alu_clk);
    operation = OP_ROL; amount = 4'd1; din = 8'h80; start = 1'b1;
    @(posedge alu_clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL b2b_no_idle: got busy %b expected 1", busy); end
    wait_done(40, cyc);
    checks++; if (cyc != 2)            begin errors++; $display("FAIL b2b_latency: got %0d expected 2", cyc); end
    checks++; if (dout !== 8'h01)      begin errors++; $display("FAIL b2b_out: got %h expected 01", dout); end
    checks++; if (carry_out !== 1'b1)  begin errors++; $display("FAIL b2b_carry: got %b expected 1", carry_out); end
    @(posedge alu_clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_to_idle: got done %b busy %b expected 0 0", done, busy);
    end
  endtask

  task automatic test_clear;
    int pulses;
    launch(OP_SHR, 4'd7, 8'hFF);
    @(posedge alu_clk); #1;
    @(negedge alu_clk); clear = 1'b1;
    @(posedge alu_clk); #1;
    checks++; if (dout !== 8'h00)      begin errors++; $display("FAIL clear_out: got %h expected 00", dout); end
    checks++; if (carry_out !== 1'b0)  begin errors++; $display("FAIL clear_carry: got %b expected 0", carry_out); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL clear_busy: got %b expected 0", busy); end
`ifdef SHIFT_UNIT_FLAGS_EN
    checks++; if (zero_out !== 1'b1)   begin errors++; $display("FAIL clear_zero: got %b expected 1", zero_out); end
`endif
    @(negedge alu_clk); clear = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge alu_clk); #1;
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses != 0)         begin errors++; $display("FAIL clear_no_done: got %0d expected 0", pulses); end
  endtask

  task automatic test_async_reset;
    int cyc;
    int pulses;
    launch(OP_SHL, 4'd1, 8'h81);
    wait_done(40, cyc);
    checks++; if (dout !== 8'h02)      begin errors++; $display("FAIL prereset_out: got %h expected 02", dout); end
    launch(OP_ROL, 4'd6, 8'h55);
    @(posedge alu_clk);
    #3 alu_rst = 1'b1;
    #1;
    checks++; if (dout !== 8'h00)      begin errors++; $display("FAIL areset_out: got %h expected 00", dout); end
    checks++; if (carry_out !== 1'b0)  begin errors++; $display("FAIL areset_carry: got %b expected 0", carry_out); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL areset_done: got %b expected 0", done); end
    @(negedge alu_clk);
    @(negedge alu_clk); alu_rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge alu_clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++; if (pulses != 0)         begin errors++; $display("FAIL areset_no_resume: got %0d active cycles expected 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_shl();
    test_sar_shr();
    test_carry_rotates();
    test_pass_amount0();
    test_large_amount();
    test_start_ignored();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
